// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer and the main control unit that drives it.
// States, shifter commands, amount-select codes and the supported funct values.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_WB    = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OP_HOLD    = 3'b000,
      OP_LOAD    = 3'b001,
      OP_LEFT    = 3'b010,
      OP_RIGHT_L = 3'b011,
      OP_RIGHT_A = 3'b100
   } shift_op_e;

   typedef enum logic [1:0] {
      SEL_SHAMT = 2'b00,
      SEL_MDR   = 2'b01,
      SEL_B     = 2'b10
   } amt_sel_e;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_SRAV = 6'h07;

   // Mirrors the external amount mux so the latched amount matches what the shifter sees.
   function automatic logic [4:0] pick_amt(input amt_sel_e   sel,
                                           input logic [4:0] shamt,
                                           input logic [4:0] mdr_amt,
                                           input logic [4:0] b_amt);
      case (sel)
         SEL_MDR: pick_amt = mdr_amt;
         SEL_B:   pick_amt = b_amt;
         default: pick_amt = shamt;
      endcase
   endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/command bundle between the main control unit (master) and the shift sequencer (slave).
interface shift_seq_if;

   logic       start;
   logic [5:0] funct;
   logic       mem_src;
   logic [4:0] shamt;
   logic [4:0] mdr_amt;
   logic [4:0] b_amt;

   logic [1:0] shift_amt_sel;
   logic [2:0] shift_op;
   logic       busy;
   logic       done;
   logic       illegal;
   logic [4:0] amt_q;

   modport master (
      output start, funct, mem_src, shamt, mdr_amt, b_amt,
      input  shift_amt_sel, shift_op, busy, done, illegal, amt_q
   );

   modport slave (
      input  start, funct, mem_src, shamt, mdr_amt, b_amt,
      output shift_amt_sel, shift_op, busy, done, illegal, amt_q
   );

endinterface

// File: rtl/shift_seq_decode.sv
// Combinational funct decode: legality, shift direction and amount source.
// No state; results are only consumed at the accept edge.
module shift_decode
   import shift_seq_pkg::*;
(
   input  logic [5:0] funct,
   input  logic       mem_src,
   output logic       legal,
   output shift_op_e  dir,
   output amt_sel_e   sel
);

   always_comb begin
      legal = 1'b1;
      dir   = OP_HOLD;
      sel   = mem_src ? SEL_MDR : SEL_SHAMT;
      case (funct)
         FUNCT_SLL:  dir = OP_LEFT;
         FUNCT_SRL:  dir = OP_RIGHT_L;
         FUNCT_SRA:  dir = OP_RIGHT_A;
         // Variable forms always take the amount from register B, whatever mem_src says.
         FUNCT_SLLV: begin dir = OP_LEFT;    sel = SEL_B; end
         FUNCT_SRLV: begin dir = OP_RIGHT_L; sel = SEL_B; end
         FUNCT_SRAV: begin dir = OP_RIGHT_A; sel = SEL_B; end
         default: begin
            legal = 1'b0;
            sel   = SEL_SHAMT;
         end
      endcase
   end

endmodule

// File: rtl/shift_seq.sv
// Shift sequencer: IDLE -> LOAD -> SHIFT -> WB, done 3 cycles after start (2 when a zero amount is bypassed).
// No queuing: start is only honoured in IDLE; all outputs come from flops or the state register.
module shift_seq
   import shift_seq_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   shift_seq_if.slave  sif
);

   state_e    state_q, state_d;
   shift_op_e dir_q,   dir_d;
   amt_sel_e  sel_q,   sel_d;
   logic [4:0] amt_q,  amt_d;
   logic      illegal_q, illegal_d;

   logic      dec_legal;
   shift_op_e dec_dir;
   amt_sel_e  dec_sel;

   shift_decode u_decode (
      .funct   (sif.funct),
      .mem_src (sif.mem_src),
      .legal   (dec_legal),
      .dir     (dec_dir),
      .sel     (dec_sel)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      sel_d     = sel_q;
      amt_d     = amt_q;
      illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sif.start) begin
               if (dec_legal) begin
                  state_d = ST_LOAD;
                  dir_d   = dec_dir;
                  sel_d   = dec_sel;
                  amt_d   = pick_amt(dec_sel, sif.shamt, sif.mdr_amt, sif.b_amt);
               end else begin
                  // Rejected request keeps the previous trace values intact.
                  illegal_d = 1'b1;
               end
            end
         end
         ST_LOAD:  state_d = (SKIP_ZERO && (amt_q == 5'd0)) ? ST_WB : ST_SHIFT;
         ST_SHIFT: state_d = ST_WB;
         ST_WB:    state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         dir_q     <= OP_HOLD;
         sel_q     <= SEL_SHAMT;
         amt_q     <= 5'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         sel_q     <= sel_d;
         amt_q     <= amt_d;
         illegal_q <= illegal_d;
      end
   end

   assign sif.busy          = (state_q != ST_IDLE);
   assign sif.done          = (state_q == ST_WB);
   assign sif.illegal       = illegal_q;
   assign sif.amt_q         = amt_q;
   assign sif.shift_amt_sel = (state_q == ST_IDLE) ? SEL_SHAMT : sel_q;
   assign sif.shift_op      = (state_q == ST_LOAD)  ? OP_LOAD :
                              (state_q == ST_SHIFT) ? dir_q   : OP_HOLD;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a done-driven scoreboard of expected select/amount.
module tb_shift_seq;

   typedef struct packed {
      logic [1:0] sel;
      logic [4:0] amt;
   } exp_t;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   shift_seq_if sif();

   shift_seq #(.SKIP_ZERO(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .sif   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] f, input logic ms,
                                  input logic [4:0] sh, input logic [4:0] md, input logic [4:0] b);
      exp_t e;
      if (f == 6'h04 || f == 6'h06 || f == 6'h07) begin
         e.sel = 2'b10; e.amt = b;
      end else if (ms) begin
         e.sel = 2'b01; e.amt = md;
      end else begin
         e.sel = 2'b00; e.amt = sh;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] f, input logic ms,
                        input logic [4:0] sh, input logic [4:0] md, input logic [4:0] b);
      sif.funct   = f;
      sif.mem_src = ms;
      sif.shamt   = sh;
      sif.mdr_amt = md;
      sif.b_amt   = b;
      sif.start   = 1'b1;
   endtask

   // Scoreboard side: every done must match the oldest accepted request.
   always @(negedge clk) begin : mon
      exp_t e;
      chk("done_illegal_excl", 32'(sif.done & sif.illegal), 32'd0);
      if (sif.done === 1'b1) begin
         done_cnt++;
         chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_sel", 32'(sif.shift_amt_sel), 32'(e.sel));
            chk("sb_amt", 32'(sif.amt_q), 32'(e.amt));
         end
      end
   end

   initial begin
      int d0;
      int d1;
      sif.start = 1'b0; sif.funct = 6'h00; sif.mem_src = 1'b0;
      sif.shamt = 5'd0; sif.mdr_amt = 5'd0; sif.b_amt = 5'd0;
      reset = 1'b1;
      #2 reset = 1'b0;

      // start held while in reset must not be accepted
      drive(6'h00, 1'b0, 5'd3, 5'd0, 5'd0);
      tick(); tick();
      chk("rst_busy",    32'(sif.busy),          32'd0);
      chk("rst_sel",     32'(sif.shift_amt_sel), 32'd0);
      chk("rst_op",      32'(sif.shift_op),      32'd0);
      chk("rst_done",    32'(sif.done),          32'd0);
      chk("rst_illegal", 32'(sif.illegal),       32'd0);
      chk("rst_amt",     32'(sif.amt_q),         32'd0);
      sif.start = 1'b0;
      reset = 1'b1;
      tick();
      chk("post_rst_idle", 32'(sif.busy), 32'd0);

      // sll immediate, shamt=4
      drive(6'h00, 1'b0, 5'd4, 5'd9, 5'd17);
      sb.push_back(model(6'h00, 1'b0, 5'd4, 5'd9, 5'd17));
      tick(); sif.start = 1'b0;
      chk("sll_p1_sel",  32'(sif.shift_amt_sel), 32'd0);
      chk("sll_p1_op",   32'(sif.shift_op),      32'd1);
      chk("sll_p1_busy", 32'(sif.busy),          32'd1);
      chk("sll_p1_done", 32'(sif.done),          32'd0);
      tick();
      chk("sll_p2_op",   32'(sif.shift_op),      32'd2);
      tick();
      chk("sll_p3_done", 32'(sif.done),          32'd1);
      chk("sll_p3_op",   32'(sif.shift_op),      32'd0);
      chk("sll_p3_amt",  32'(sif.amt_q),         32'd4);
      tick();
      chk("sll_idle_busy", 32'(sif.busy),        32'd0);
      chk("sll_idle_done", 32'(sif.done),        32'd0);

      // srav with zero B amount: SHIFT bypassed, mem_src ignored
      drive(6'h07, 1'b1, 5'd12, 5'd21, 5'd0);
      sb.push_back(model(6'h07, 1'b1, 5'd12, 5'd21, 5'd0));
      tick(); sif.start = 1'b0;
      chk("srav_p1_sel", 32'(sif.shift_amt_sel), 32'd2);
      chk("srav_p1_op",  32'(sif.shift_op),      32'd1);
      chk("srav_p1_amt", 32'(sif.amt_q),         32'd0);
      tick();
      chk("srav_p2_done", 32'(sif.done),          32'd1);
      chk("srav_p2_op",   32'(sif.shift_op),      32'd0);
      chk("srav_p2_sel",  32'(sif.shift_amt_sel), 32'd2);
      tick();
      chk("srav_idle", 32'(sif.busy), 32'd0);

      // srl with amount from MDR = 31
      drive(6'h02, 1'b1, 5'd6, 5'd31, 5'd3);
      sb.push_back(model(6'h02, 1'b1, 5'd6, 5'd31, 5'd3));
      tick(); sif.start = 1'b0;
      chk("srl_p1_sel", 32'(sif.shift_amt_sel), 32'd1);
      chk("srl_p1_op",  32'(sif.shift_op),      32'd1);
      tick();
      chk("srl_p2_sel", 32'(sif.shift_amt_sel), 32'd1);
      chk("srl_p2_op",  32'(sif.shift_op),      32'd3);
      tick();
      chk("srl_p3_done", 32'(sif.done),          32'd1);
      chk("srl_p3_sel",  32'(sif.shift_amt_sel), 32'd1);
      chk("srl_p3_amt",  32'(sif.amt_q),         32'd31);
      tick();
      chk("srl_idle_sel", 32'(sif.shift_amt_sel), 32'd0);

      // illegal funct 0x05, then sra accepted right after
      drive(6'h05, 1'b0, 5'd7, 5'd0, 5'd0);
      tick();
      chk("ill_pulse", 32'(sif.illegal), 32'd1);
      chk("ill_busy",  32'(sif.busy),    32'd0);
      chk("ill_amt",   32'(sif.amt_q),   32'd31);
      chk("ill_done",  32'(sif.done),    32'd0);
      drive(6'h03, 1'b0, 5'd9, 5'd0, 5'd0);
      sb.push_back(model(6'h03, 1'b0, 5'd9, 5'd0, 5'd0));
      tick(); sif.start = 1'b0;
      chk("sra_p1_ill",  32'(sif.illegal),  32'd0);
      chk("sra_p1_busy", 32'(sif.busy),     32'd1);
      chk("sra_p1_op",   32'(sif.shift_op), 32'd1);
      chk("sra_p1_amt",  32'(sif.amt_q),    32'd9);
      tick();
      chk("sra_p2_op", 32'(sif.shift_op), 32'd4);
      tick();
      chk("sra_p3_done", 32'(sif.done), 32'd1);
      tick();

      // sllv with start re-pulsed during LOAD and WB
      d0 = done_cnt;
      drive(6'h04, 1'b0, 5'd0, 5'd0, 5'd13);
      sb.push_back(model(6'h04, 1'b0, 5'd0, 5'd0, 5'd13));
      tick();
      drive(6'h06, 1'b0, 5'd0, 5'd0, 5'd2);
      tick(); sif.start = 1'b0;
      chk("rep_shift_op",  32'(sif.shift_op), 32'd2);
      chk("rep_shift_amt", 32'(sif.amt_q),    32'd13);
      tick();
      chk("rep_wb_done", 32'(sif.done), 32'd1);
      drive(6'h00, 1'b0, 5'd1, 5'd0, 5'd0);
      tick(); sif.start = 1'b0;
      chk("rep_after_wb_busy", 32'(sif.busy), 32'd0);
      tick();
      chk("rep_still_idle", 32'(sif.busy), 32'd0);
      chk("rep_one_done", 32'(done_cnt - d0), 32'd1);

      // reset asserted in SHIFT
      drive(6'h00, 1'b0, 5'd5, 5'd0, 5'd0);
      sb.push_back(model(6'h00, 1'b0, 5'd5, 5'd0, 5'd0));
      tick(); sif.start = 1'b0;
      tick();
      chk("rstmid_in_shift", 32'(sif.shift_op), 32'd2);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_busy",    32'(sif.busy),          32'd0);
      chk("rstmid_op",      32'(sif.shift_op),      32'd0);
      chk("rstmid_sel",     32'(sif.shift_amt_sel), 32'd0);
      chk("rstmid_done",    32'(sif.done),          32'd0);
      chk("rstmid_illegal", 32'(sif.illegal),       32'd0);
      chk("rstmid_amt",     32'(sif.amt_q),         32'd0);
      sb.delete();
      d1 = done_cnt;
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      chk("rstmid_no_done", 32'(done_cnt - d1), 32'd0);

      // fresh sll after reset
      drive(6'h00, 1'b0, 5'd6, 5'd0, 5'd0);
      sb.push_back(model(6'h00, 1'b0, 5'd6, 5'd0, 5'd0));
      tick(); sif.start = 1'b0;
      chk("fresh_p1_op", 32'(sif.shift_op), 32'd1);
      tick();
      chk("fresh_p2_op", 32'(sif.shift_op), 32'd2);
      tick();
      chk("fresh_p3_done", 32'(sif.done),  32'd1);
      chk("fresh_p3_amt",  32'(sif.amt_q), 32'd6);
      tick(); tick();

      chk("sb_empty",   32'(sb.size()), 32'd0);
      chk("done_total", 32'(done_cnt),  32'd6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: SKIP_ZERO, default 1; 1 = bypass the SHIFT state when the latched amount is 0.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 start  input  1  one-cycle request from the main control unit; sampled only in IDLE.
REQ-005 funct  input  6  shift function code: 0x00 sll, 0x02 srl, 0x03 sra, 0x04 sllv, 0x06 srlv, 0x07 srav.
REQ-006 mem_src  input  1  1 = amount comes from memory data register (immediate-form ops only).
REQ-007 shamt  input  5  instruction shamt field.
REQ-008 mdr_amt  input  5  memory data register low bits.
REQ-009 b_amt  input  5  register B low bits.
REQ-010 shift_amt_sel  output  2  amount mux select: 00 shamt, 01 MDR, 10 B.
REQ-011 shift_op  output  3  shifter command: 000 hold, 001 load, 010 left, 011 right logical, 100 right arithmetic.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; shifter result valid for write-back.
REQ-014 illegal  output  1  one-cycle pulse for an unsupported funct.
REQ-015 amt_q  output  5  amount latched at accept, for debug and trace.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, WB.
REQ-017 Accept: IDLE with start=1 and a legal funct SHALL go to LOAD next edge and latch the op, the select and amt_q.
REQ-018 Select rule: variable ops (0x04/0x06/0x07) SHALL use sel=10; immediate ops SHALL use sel=01 when mem_src=1, else sel=00.
REQ-019 mem_src SHALL be ignored for variable ops.
REQ-020 amt_q SHALL latch the source chosen by REQ-018, sampled in the accept cycle.
REQ-021 LOAD SHALL drive shift_op=001 for exactly one cycle.
REQ-022 From LOAD the FSM SHALL go to WB if SKIP_ZERO=1 and amt_q=0; otherwise it SHALL go to SHIFT.
REQ-023 SHIFT SHALL drive the decoded direction code for exactly one cycle, then go to WB.
  - sll/sllv -> 010
  - srl/srlv -> 011
  - sra/srav -> 100
REQ-024 WB SHALL drive shift_op=000 and done=1 for one cycle, then return to IDLE.
REQ-025 Latency SHALL be 3 cycles from start to done (2 when bypassed).
REQ-026 shift_amt_sel SHALL hold its latched value from LOAD through WB.
REQ-027 shift_amt_sel SHALL be 00 in IDLE.
REQ-028 shift_op SHALL be 000 in IDLE.
REQ-029 start SHALL be ignored while busy=1, with no queuing.
REQ-030 start in the WB cycle SHALL be ignored; a new request needs start with busy=0.
REQ-031 Illegal funct with start in IDLE SHALL pulse illegal the next cycle and stay in IDLE.
REQ-032 An illegal accept SHALL leave the latched op, select and amt_q unchanged.
REQ-033 done and illegal SHALL never be high in the same cycle.
REQ-034 All outputs SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-035 Asserting reset SHALL immediately, at any point including mid-sequence, force the following; no done pulse SHALL follow.
  - state IDLE
  - shift_amt_sel=00, shift_op=000
  - busy=0, done=0, illegal=0, amt_q=0
REQ-036 The first accept after deassertion SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-037 A shared package SHALL hold the items below, for reuse by the main control unit.
  - state encoding
  - shift_op codes (001..100)
  - amount-select codes (00/01/10)
  - funct constants
REQ-038 One sub-module, shift_decode, SHALL be combinational: funct + mem_src in; legal flag, direction code and select out.
REQ-039 The FSM and output registers SHALL live in shift_seq.

Verification
REQ-040 sll, funct=0x00, shamt=4, mem_src=0: sel=00 and op=001 at +1, op=010 at +2, done at +3, amt_q=4.
REQ-041 srav, funct=0x07, b_amt=0, SKIP_ZERO=1: sel=10 and op=001 at +1, done at +2, no SHIFT cycle.
REQ-042 srl, funct=0x02, mem_src=1, mdr_amt=31: sel=01 through WB, op=011 at +2, amt_q=31.
REQ-043 funct=0x05 with start: illegal pulse at +1, busy stays 0, then legal sra (0x03) is accepted the next cycle.
REQ-044 start re-pulsed during LOAD and WB: exactly one done per accepted request.
REQ-045 reset asserted in SHIFT: outputs go to reset values before the next edge, no done, and a fresh sll completes normally.
